// File: rtl/rbzero_spi_pkg.sv
// rtl/rbzero_spi_pkg.sv - shared constants and state encoding for the rbzero SPI sequencer
package rbzero_spi_pkg;

    localparam logic TGT_VEC = 1'b0;
    localparam logic TGT_REG = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VB  = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - H-cycle divider emitting a one-cycle tick at the end of each half-period
module spi_half_tick #(
    parameter int CLK_DIV = 2,
    parameter int CNT_W   = $clog2(CLK_DIV + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/la_spi_sequencer.sv
// rtl/la_spi_sequencer.sv - parallel-to-SPI master feeding rbzero's vec and reg slave ports
module la_spi_sequencer
    import rbzero_spi_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int LEN_W    = 7,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic                i_target,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [MAX_BITS-1:0] i_data,
    input  logic                i_sync_vblank,
    input  logic                i_vblank,
    output logic                o_ack,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_vec_csb,
    output logic                o_vec_sclk,
    output logic                o_vec_mosi,
    output logic                o_reg_csb,
    output logic                o_reg_sclk,
    output logic                o_reg_mosi
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_target;
    logic                r_err;
    logic [LEN_W-1:0]    r_bits;
    logic [MAX_BITS-1:0] r_shift;

    logic w_tick;
    logic w_clr;
    logic w_len_ok;
    logic w_capture;
    logic w_active;
    logic w_sclk;
    logic w_mosi;

    assign w_len_ok  = (i_len != '0) && (i_len <= MAX_LEN);
    assign w_capture = (r_state == ST_IDLE) && i_req;
    // Restart the half-period count on every state entry so each phase is exactly H cycles.
    assign w_clr     = (w_state_next != r_state);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_target <= TGT_VEC;
            r_err    <= 1'b0;
            r_bits   <= '0;
            r_shift  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_target <= i_target;
                r_err    <= !w_len_ok;
                r_bits   <= i_len;
                // Left-align so the payload MSB always sits at the shifter's top bit.
                r_shift  <= i_data << (MAX_LEN - i_len);
            end else if ((r_state == ST_SHIFT_HI) && w_tick) begin
                r_bits  <= r_bits - 1'b1;
                r_shift <= {r_shift[MAX_BITS-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (!w_len_ok)          w_state_next = ST_GAP;
                    else if (i_sync_vblank) w_state_next = ST_WAIT_VB;
                    else                    w_state_next = ST_SHIFT_LO;
                end
            end
            ST_WAIT_VB:  if (i_vblank) w_state_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_tick)   w_state_next = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (w_tick) w_state_next = (r_bits == LEN_W'(1)) ? ST_HOLD : ST_SHIFT_LO;
            end
            ST_HOLD:     if (w_tick)   w_state_next = ST_GAP;
            ST_GAP:      if (w_tick)   w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ack      = w_capture;
        o_busy     = (r_state != ST_IDLE);
        o_done     = (r_state == ST_GAP) && w_tick;
        o_err      = (r_state == ST_GAP) && w_tick && r_err;
        w_active   = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) || (r_state == ST_HOLD);
        w_sclk     = (r_state == ST_SHIFT_HI);
        w_mosi     = ((r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI)) && r_shift[MAX_BITS-1];
        o_vec_csb  = 1'b1;
        o_vec_sclk = 1'b0;
        o_vec_mosi = 1'b0;
        o_reg_csb  = 1'b1;
        o_reg_sclk = 1'b0;
        o_reg_mosi = 1'b0;
        if (w_active) begin
            if (r_target == TGT_REG) begin
                o_reg_csb  = 1'b0;
                o_reg_sclk = w_sclk;
                o_reg_mosi = w_mosi;
            end else begin
                o_vec_csb  = 1'b0;
                o_vec_sclk = w_sclk;
                o_vec_mosi = w_mosi;
            end
        end
    end

endmodule

// File: tb/tb_la_spi_sequencer.sv
// tb/tb_la_spi_sequencer.sv - self-checking bench for la_spi_sequencer against a timing/bitstream model
module tb_la_spi_sequencer;

    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic        i_target;
    logic [6:0]  i_len;
    logic [63:0] i_data;
    logic        i_sync_vblank;
    logic        i_vblank;
    logic        o_ack, o_busy, o_done, o_err;
    logic        o_vec_csb, o_vec_sclk, o_vec_mosi;
    logic        o_reg_csb, o_reg_sclk, o_reg_mosi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    la_spi_sequencer #(
        .MAX_BITS (64),
        .LEN_W    (7),
        .CLK_DIV  (H)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_target      (i_target),
        .i_len         (i_len),
        .i_data        (i_data),
        .i_sync_vblank (i_sync_vblank),
        .i_vblank      (i_vblank),
        .o_ack         (o_ack),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_vec_csb     (o_vec_csb),
        .o_vec_sclk    (o_vec_sclk),
        .o_vec_mosi    (o_vec_mosi),
        .o_reg_csb     (o_reg_csb),
        .o_reg_sclk    (o_reg_sclk),
        .o_reg_mosi    (o_reg_mosi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction: drives the request, watches every cycle until done, then compares
    // the observed bitstream and timing with what the rules predict for (len, data, sync).
    task automatic run_txn(input logic tgt, input int len, input logic [63:0] data,
                           input logic sync, input int vb_at, input logic hold_req);
        int          first_low, last_low, low_cnt, rises, done_at, lim, exp_first, exp_done;
        logic [63:0] word, mask;
        logic [2:0]  sel, oth;
        logic        prev_sclk, prev_mosi, got_done, err_seen, legal;
        legal     = (len >= 1) && (len <= 64);
        exp_first = sync ? vb_at + 1 : 1;
        exp_done  = legal ? exp_first + 2*H*len + 2*H - 1 : H;
        mask      = (len >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << len) - 64'd1);
        first_low = -1; last_low = -1; low_cnt = 0; rises = 0; done_at = -1;
        word = '0; prev_sclk = 1'b0; prev_mosi = 1'b0; got_done = 1'b0; err_seen = 1'b0;
        lim = exp_done + 20;

        @(negedge clk);
        i_req = 1'b1; i_target = tgt; i_len = 7'(len); i_data = data;
        i_sync_vblank = sync; i_vblank = sync ? 1'b0 : 1'($urandom_range(0, 1));
        #1 chk("ack_t0", o_ack, 1);

        for (int t = 1; t <= lim && !got_done; t++) begin
            @(negedge clk);
            sel = tgt ? {o_reg_csb, o_reg_sclk, o_reg_mosi} : {o_vec_csb, o_vec_sclk, o_vec_mosi};
            oth = tgt ? {o_vec_csb, o_vec_sclk, o_vec_mosi} : {o_reg_csb, o_reg_sclk, o_reg_mosi};
            chk("no_ack_busy", o_ack, 0);
            chk("busy", o_busy, 1);
            chk("other_idle", oth, 3'b100);
            if (!sel[2]) begin
                if (first_low < 0) first_low = t;
                last_low = t;
                low_cnt++;
            end else begin
                chk("idle_when_csb_hi", sel[1:0], 0);
            end
            if (sel[1] && prev_sclk) chk("mosi_stable_hi", sel[0], prev_mosi);
            if (sel[1] && !prev_sclk) begin
                rises++;
                word = {word[62:0], sel[0]};
            end
            prev_sclk = sel[1];
            prev_mosi = sel[0];
            if (o_done) begin
                got_done = 1'b1;
                done_at  = t;
                err_seen = o_err;
            end
            if (!hold_req) i_req = 1'b0;
            i_target = 1'($urandom_range(0, 1));
            i_len    = 7'($urandom_range(0, 127));
            i_data   = {$urandom, $urandom};
            i_vblank = sync ? (t >= vb_at) : 1'($urandom_range(0, 1));
        end

        chk("done_seen", got_done, 1);
        chk("done_at", done_at, exp_done);
        chk("err", err_seen, !legal);
        chk("first_low", first_low, legal ? exp_first : -1);
        chk("last_low", last_low, legal ? exp_first + 2*H*len + H - 1 : -1);
        chk("low_cnt", low_cnt, legal ? 2*H*len + H : 0);
        chk("rises", rises, legal ? len : 0);
        chk("word", word, legal ? (data & mask) : 64'd0);
    endtask

    initial begin
        logic        bad;
        logic [63:0] rd;
        reset = 1'b1; i_req = 1'b0; i_target = 1'b0; i_len = '0; i_data = '0;
        i_sync_vblank = 1'b0; i_vblank = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {o_ack, o_busy, o_done, o_err, o_vec_csb, o_vec_sclk, o_vec_mosi, o_reg_csb, o_reg_sclk, o_reg_mosi},
            10'b0000_100_100);
        reset = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 8, 64'hA5, 1'b0, 0, 1'b0);
        run_txn(1'b0, 64, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16, 64'hBEEF, 1'b1, 50, 1'b0);
        run_txn(1'b1, 0, 64'hFFFF, 1'b0, 0, 1'b0);
        run_txn(1'b0, 65, 64'hFFFF, 1'b0, 0, 1'b0);
        run_txn(1'b1, 1, 64'h1, 1'b0, 0, 1'b0);

        // Abort during bit 3 of a reg write, then confirm a clean restart.
        @(negedge clk);
        rd = {$urandom, $urandom};
        i_req = 1'b1; i_target = 1'b1; i_len = 7'd8; i_data = rd; i_sync_vblank = 1'b0;
        #1 chk("abort_ack", o_ack, 1);
        repeat (10) begin
            @(negedge clk);
            i_req = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_idle",
            {o_reg_csb, o_reg_sclk, o_reg_mosi, o_vec_csb, o_vec_sclk, o_vec_mosi, o_busy, o_done},
            8'b100_100_0_0);
        reset = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_done || !o_reg_csb || o_busy) bad = 1'b1;
        end
        chk("no_done_after_abort", bad, 0);
        run_txn(1'b1, 8, rd, 1'b0, 0, 1'b0);

        // Request held high across back-to-back transfers.
        run_txn(1'b1, 5, 64'h15, 1'b0, 0, 1'b1);
        run_txn(1'b0, 12, 64'hC3A, 1'b0, 0, 1'b1);
        run_txn(1'b1, 3, 64'h6, 1'b0, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            logic s;
            s = (k % 3 == 2);
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 64)), {$urandom, $urandom},
                    s, s ? int'($urandom_range(1, 10)) : 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
